// File: rtl/pooling_output_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : pooling_output_packer_if
// Description : Stream-in / pack-out handshake bundle of the pooling packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pooling_output_packer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PACK_SIZE  = 2
);
    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_WIDTH-1:0]           data_in;
    logic                            flush;
    logic                            out_valid;
    logic                            out_ready;
    logic [PACK_SIZE*DATA_WIDTH-1:0] data_out;
    logic [2:0]                      block_idx;
    logic                            frame_done;

    modport master (
        output in_valid, data_in, flush, out_ready,
        input  in_ready, out_valid, data_out, block_idx, frame_done
    );

    modport slave (
        input  in_valid, data_in, flush, out_ready,
        output in_ready, out_valid, data_out, block_idx, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/pooling_output_packer.sv
`default_nettype none
// ============================================================================
// Module      : pooling_output_packer
// Description : Packs PACK_SIZE serial pooled words into one row word with a
//               block index; optional checks under POOL_PACK_DEBUG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pooling_output_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int PACK_SIZE  = 2,
    parameter int NUM_BLOCKS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pooling_output_packer_if.slave  bus
);
    localparam int                 c_CNT_W    = $clog2(PACK_SIZE + 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(PACK_SIZE);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
    localparam logic [2:0]         c_LAST_BLK = 3'(NUM_BLOCKS - 1);

    logic [DATA_WIDTH-1:0]           r_col [PACK_SIZE];
    logic [c_CNT_W-1:0]              r_cnt;
    logic                            r_flush_pend;
    logic [2:0]                      r_bidx;
    logic [PACK_SIZE*DATA_WIDTH-1:0] r_data_out;
    logic [2:0]                      r_block_idx;
    logic                            r_out_valid;
    logic                            r_frame_done;

    logic                            w_complete;
    logic                            w_transfer;
    logic                            w_in_ready;
    logic                            w_accept;
    logic [c_CNT_W-1:0]              w_cnt_next;
    logic [PACK_SIZE*DATA_WIDTH-1:0] w_pack;

    assign w_complete = (r_cnt == c_FULL) || (r_flush_pend && (r_cnt != '0));
    assign w_transfer = w_complete && (!r_out_valid || bus.out_ready);
    // A transfer frees col in the same cycle, so a word can still land in slot 0.
    assign w_in_ready = !r_flush_pend && ((r_cnt != c_FULL) || w_transfer);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_transfer) begin
            w_cnt_next = w_accept ? c_ONE : '0;
        end else if (w_accept) begin
            w_cnt_next = r_cnt + c_ONE;
        end
    end

    // Slot 0 (first word received) ends up in the most significant bits.
    generate
        for (genvar k = 0; k < PACK_SIZE; k++) begin : g_pack
            assign w_pack[(PACK_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH] = r_col[k];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PACK_SIZE; k++) begin
                r_col[k] <= '0;
            end
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_bidx       <= '0;
            r_data_out   <= '0;
            r_block_idx  <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            for (int k = 0; k < PACK_SIZE; k++) begin
                if (w_transfer) begin
                    r_col[k] <= (k == 0 && w_accept) ? bus.data_in : '0;
                end else if (w_accept && (r_cnt == c_CNT_W'(k))) begin
                    r_col[k] <= bus.data_in;
                end
            end
            r_cnt <= w_cnt_next;
            // A flush only survives if something is left to close.
            r_flush_pend <= (r_flush_pend && !w_transfer) ||
                            (bus.flush && (w_cnt_next != '0));

            if (w_transfer) begin
                r_data_out  <= w_pack;
                r_out_valid <= 1'b1;
                r_block_idx <= r_bidx;
                r_bidx      <= (r_bidx == c_LAST_BLK) ? 3'd0 : r_bidx + 3'd1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            r_frame_done <= r_out_valid && bus.out_ready && (r_block_idx == c_LAST_BLK);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.data_out   = r_data_out;
    assign bus.block_idx  = r_block_idx;
    assign bus.frame_done = r_frame_done;

`ifdef POOL_PACK_DEBUG_EN
    shortreal    dbg_data_in;
    shortreal    dbg_slot [PACK_SIZE];
    int unsigned r_dbg_stall;
    logic        r_dbg_prev_valid;
    logic        r_dbg_prev_ready;

    always_comb begin
        dbg_data_in = $bitstoshortreal(bus.data_in[31:0]);
        for (int k = 0; k < PACK_SIZE; k++) begin
            dbg_slot[k] = $bitstoshortreal(r_data_out[(PACK_SIZE-k)*DATA_WIDTH-1 -: 32]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_stall      <= 0;
            r_dbg_prev_valid <= 1'b0;
            r_dbg_prev_ready <= 1'b0;
        end else begin
            if (bus.in_valid && !w_in_ready) begin
                r_dbg_stall <= r_dbg_stall + 1;
                if (r_dbg_stall + 1 > 2 * PACK_SIZE) begin
                    $error("pooling_output_packer: in_valid stalled for %0d cycles", r_dbg_stall + 1);
                end
            end else begin
                r_dbg_stall <= 0;
            end
            r_dbg_prev_valid <= r_out_valid;
            r_dbg_prev_ready <= bus.out_ready;
            if (r_dbg_prev_valid && !r_dbg_prev_ready && !r_out_valid) begin
                $error("pooling_output_packer: out_valid dropped without handshake");
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pooling_output_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pooling_output_packer
// Description : Directed self-checking bench for pooling_output_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pooling_output_packer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec;
    int   n_err;

    always #5 clk = ~clk;

    pooling_output_packer_if #(.DATA_WIDTH(32), .PACK_SIZE(2)) bus ();

    pooling_output_packer #(
        .DATA_WIDTH (32),
        .PACK_SIZE  (2),
        .NUM_BLOCKS (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int i);
        if (i == 0)      return 32'h3F80_0000;
        else if (i == 1) return 32'h4000_0000;
        else             return 32'h1000_0000 + 32'(i);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_in_ready",   64'(bus.in_ready),   64'd1);
        chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
        chk("rst_data_out",   bus.data_out,        64'd0);
        chk("rst_block_idx",  64'(bus.block_idx),  64'd0);
        chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
        rst_n = 1'b1;
        cyc();

        // 14 words back-to-back: packs 0..5 then wrap to 0
        for (int i = 0; i < 16; i++) begin
            if (i >= 3 && (i % 2) == 1) begin
                chk("stream_out_valid", 64'(bus.out_valid), 64'd1);
                chk("stream_data_out",  bus.data_out,
                    {word(i - 3), word(i - 2)});
                chk("stream_block_idx", 64'(bus.block_idx), 64'(((i - 3) / 2) % 6));
            end else begin
                chk("stream_out_idle",  64'(bus.out_valid), 64'd0);
            end
            chk("stream_frame_done", 64'(bus.frame_done), 64'(i == 14));
            if (i < 14) begin
                bus.in_valid = 1'b1;
                bus.data_in  = word(i);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (i < 14) chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
            cyc();
        end

        // Backpressure: packs 1 and 2
        bus.in_valid = 1'b1; bus.data_in = 32'h3F80_0000; cyc();
        bus.data_in = 32'h4000_0000; cyc();
        bus.data_in = 32'h1111_1111; bus.out_ready = 1'b0; cyc();
        bus.data_in = 32'h2222_2222; cyc();
        bus.data_in = 32'h3333_3333;
        #1;
        chk("bp_in_ready_low",  64'(bus.in_ready),  64'd0);
        chk("bp_out_valid",     64'(bus.out_valid), 64'd1);
        chk("bp_data_hold",     bus.data_out,       64'h3F80_0000_4000_0000);
        chk("bp_block_idx",     64'(bus.block_idx), 64'd1);
        cyc();
        chk("bp_data_hold2",    bus.data_out,       64'h3F80_0000_4000_0000);
        chk("bp_block_idx2",    64'(bus.block_idx), 64'd1);
        chk("bp_in_ready_low2", 64'(bus.in_ready),  64'd0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 64'(bus.in_ready), 64'd1);
        cyc();
        chk("bp_second_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_second_data",  bus.data_out,       64'h1111_1111_2222_2222);
        chk("bp_second_idx",   64'(bus.block_idx), 64'd2);
        cyc();
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // Flush of a partial pack (pack 3)
        bus.in_valid = 1'b1; bus.data_in = 32'h4040_0000; cyc();
        bus.in_valid = 1'b0; bus.flush = 1'b1; cyc();
        bus.flush = 1'b0;
        #1;
        chk("flush_pend_in_ready", 64'(bus.in_ready),  64'd0);
        chk("flush_pend_no_out",   64'(bus.out_valid), 64'd0);
        cyc();
        chk("flush_out_valid", 64'(bus.out_valid), 64'd1);
        chk("flush_data_out",  bus.data_out,       64'h4040_0000_0000_0000);
        chk("flush_block_idx", 64'(bus.block_idx), 64'd3);
        cyc();
        chk("flush_done_in_ready", 64'(bus.in_ready), 64'd1);

        // Flush with empty col is ignored
        bus.flush = 1'b1; cyc();
        bus.flush = 1'b0; cyc(); cyc();
        chk("flush_empty_no_out",  64'(bus.out_valid), 64'd0);
        chk("flush_empty_ready",   64'(bus.in_ready),  64'd1);

        // Flush together with an accept (pack 4)
        bus.in_valid = 1'b1; bus.data_in = 32'h4444_4444; bus.flush = 1'b1; cyc();
        bus.in_valid = 1'b0; bus.flush = 1'b0; cyc();
        chk("flush_acc_valid", 64'(bus.out_valid), 64'd1);
        chk("flush_acc_data",  bus.data_out,       64'h4444_4444_0000_0000);
        chk("flush_acc_idx",   64'(bus.block_idx), 64'd4);
        cyc();

        // Reset mid-operation with a held pack (5) and a partial pack
        bus.in_valid = 1'b1; bus.data_in = 32'h5555_5555; cyc();
        bus.data_in = 32'h6666_6666; cyc();
        bus.data_in = 32'h7777_7777; bus.out_ready = 1'b0; cyc();
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("pre_rst_idx",   64'(bus.block_idx), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",    64'(bus.out_valid),  64'd0);
        chk("async_rst_data",     bus.data_out,        64'd0);
        chk("async_rst_idx",      64'(bus.block_idx),  64'd0);
        chk("async_rst_frame",    64'(bus.frame_done), 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b1; bus.data_in = 32'hAAAA_0001; cyc();
        bus.data_in = 32'hAAAA_0002; cyc();
        bus.in_valid = 1'b0; cyc();
        chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("post_rst_data",  bus.data_out,       64'hAAAA_0001_AAAA_0002);
        chk("post_rst_idx",   64'(bus.block_idx), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
